// File: rtl/rhandler_pkg.sv
// Shared types and constants for the AXI4-Lite 64-to-32 read handler.
package rhandler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LO_AR,
        LO_R,
        HI_AR,
        HI_R,
        RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         DWORD_OFFSET = 4;

    function automatic logic is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/rhandler_ctrl.sv
// Read handler FSM: sequences the lower/upper slave reads and drives all handshakes.
// With RHANDLER_ERR_ABORT_EN defined, a failing lower read skips the upper read.
module rhandler_ctrl
    import rhandler_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic addrbit2,
    input  logic m_arvalid,
    input  logic m_rready,
    input  logic s_arready,
    input  logic s_rvalid,
    input  logic lo_err,
    output logic m_arready,
    output logic m_rvalid,
    output logic s_arvalid,
    output logic s_rready,
    output logic accept,
    output logic lo_cap,
    output logic hi_cap,
    output logic hi_phase
);

    state_t state, next_state;
    logic   active;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            active <= 1'b0;
        end else begin
            state  <= next_state;
            active <= 1'b1;
        end
    end

    // active keeps m_arready low while reset is held, yet IDLE is still the reset state.
    assign m_arready = active && (state == IDLE);
    assign m_rvalid  = (state == RESP);
    assign s_arvalid = (state == LO_AR) || (state == HI_AR);
    assign s_rready  = (state == LO_R)  || (state == HI_R);
    assign hi_phase  = (state == HI_AR) || (state == HI_R);
    assign accept    = m_arready && m_arvalid;
    assign lo_cap    = (state == LO_R) && s_rvalid;
    assign hi_cap    = (state == HI_R) && s_rvalid;

`ifndef RHANDLER_ERR_ABORT_EN
    logic unused_lo_err;
    assign unused_lo_err = lo_err;
`endif

    // NOTE: next_state gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept)    next_state = addrbit2 ? HI_AR : LO_AR;
            LO_AR: if (s_arready) next_state = LO_R;
            LO_R: begin
                if (s_rvalid) begin
`ifdef RHANDLER_ERR_ABORT_EN
                    next_state = lo_err ? RESP : HI_AR;
`else
                    next_state = HI_AR;
`endif
                end
            end
            HI_AR: if (s_arready) next_state = HI_R;
            HI_R:  if (s_rvalid)  next_state = RESP;
            RESP:  if (m_rready)  next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/rhandler.sv
// AXI4-Lite 64-to-32 read handler: one 64-bit master read becomes one or two 32-bit slave reads.
// Optional RHANDLER_ERR_ABORT_EN (see rhandler_ctrl) aborts after a failing lower dword.
module rhandler
    import rhandler_pkg::*;
#(
    parameter int M_ARADDR_WIDTH = 32,
    parameter int S_ARADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [M_ARADDR_WIDTH-1:0] m_araddr,
    input  logic                      m_arvalid,
    output logic                      m_arready,
    output logic [63:0]               m_rdata,
    output logic [1:0]                m_rresp,
    output logic                      m_rvalid,
    input  logic                      m_rready,
    output logic [S_ARADDR_WIDTH-1:0] s_araddr,
    output logic                      s_arvalid,
    input  logic                      s_arready,
    input  logic [31:0]               s_rdata,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rvalid,
    output logic                      s_rready
);

    localparam int AW = (M_ARADDR_WIDTH > S_ARADDR_WIDTH) ? M_ARADDR_WIDTH : S_ARADDR_WIDTH;

    logic [M_ARADDR_WIDTH-1:0] addr_q;
    logic [31:0]               lo_q, hi_q;
    logic                      err_q;
    logic                      accept, lo_cap, hi_cap, hi_phase;
    logic [AW-1:0]             addr_ext, addr_sel;

    rhandler_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .addrbit2  (m_araddr[2]),
        .m_arvalid (m_arvalid),
        .m_rready  (m_rready),
        .s_arready (s_arready),
        .s_rvalid  (s_rvalid),
        .lo_err    (is_err(s_rresp)),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .s_arvalid (s_arvalid),
        .s_rready  (s_rready),
        .accept    (accept),
        .lo_cap    (lo_cap),
        .hi_cap    (hi_cap),
        .hi_phase  (hi_phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            addr_q <= m_araddr;
            lo_q   <= '0;
            hi_q   <= '0;
            err_q  <= 1'b0;
        end else if (lo_cap) begin
            lo_q  <= s_rdata;
            err_q <= err_q | is_err(s_rresp);
        end else if (hi_cap) begin
            hi_q  <= s_rdata;
            err_q <= err_q | is_err(s_rresp);
        end
    end

    // The +4 only touches bit 2 upward, so the byte offset in bits [1:0] is preserved.
    assign addr_ext = AW'(addr_q);
    assign addr_sel = (hi_phase && !addr_q[2]) ? addr_ext + AW'(DWORD_OFFSET) : addr_ext;
    assign s_araddr = addr_sel[S_ARADDR_WIDTH-1:0];

    assign m_rdata = {hi_q, lo_q};
    assign m_rresp = err_q ? RESP_SLVERR : RESP_OKAY;

endmodule
